// File: rtl/spw_link_fsm_if.sv
// rtl/spw_link_fsm_if.sv - host/receiver/transmitter signal bundle for the SpaceWire link FSM
`timescale 1ns/1ps

interface spw_link_fsm_if;
  logic       link_start;
  logic       link_disable;
  logic       auto_start;
  logic       rx_got_bit;
  logic       rx_got_null;
  logic       rx_got_fct;
  logic       rx_got_nchar;
  logic       rx_got_time_code;
  logic       rx_error;
  logic       credit_error;
  logic       rx_resetn;
  logic       enable_tx;
  logic       send_null_tx;
  logic       send_fct_tx;
  logic       send_data_tx;
  logic [2:0] fsm_state;
  logic       disconnect_err;

  modport master (
    input  link_start, link_disable, auto_start, rx_got_bit, rx_got_null,
           rx_got_fct, rx_got_nchar, rx_got_time_code, rx_error, credit_error,
    output rx_resetn, enable_tx, send_null_tx, send_fct_tx, send_data_tx,
           fsm_state, disconnect_err
  );

  modport slave (
    output link_start, link_disable, auto_start, rx_got_bit, rx_got_null,
           rx_got_fct, rx_got_nchar, rx_got_time_code, rx_error, credit_error,
    input  rx_resetn, enable_tx, send_null_tx, send_fct_tx, send_data_tx,
           fsm_state, disconnect_err
  );
endinterface

// File: rtl/spw_link_fsm.sv
// rtl/spw_link_fsm.sv - SpaceWire exchange-level link state machine with disconnect detection
// Optional auto-start from a received NULL is enabled by defining SPW_AUTOSTART_EN.
`timescale 1ns/1ps

module spw_link_fsm #(
  parameter int T6_4US      = 640,
  parameter int T12_8US     = 1280,
  parameter int DISC_CYCLES = 85,
  parameter int TIMER_W     = 12
) (
  input  logic          pclk,
  input  logic          reset,
  spw_link_fsm_if.master bus
);

  typedef enum logic [2:0] {
    S_ERROR_RESET = 3'd0,
    S_ERROR_WAIT  = 3'd1,
    S_READY       = 3'd2,
    S_STARTED     = 3'd3,
    S_CONNECTING  = 3'd4,
    S_RUN         = 3'd5
  } state_e;

  localparam logic [TIMER_W-1:0] RESET_LAST = TIMER_W'(T6_4US - 1);
  localparam logic [TIMER_W-1:0] WAIT_LAST  = TIMER_W'(T12_8US - 1);
  localparam logic [TIMER_W-1:0] DISC_LAST  = TIMER_W'(DISC_CYCLES - 1);
  localparam logic [TIMER_W-1:0] COUNT_MAX  = '1;

  state_e               state_q, state_d;
  logic [TIMER_W-1:0]   timer_q, timer_d;
  logic [TIMER_W-1:0]   disc_cnt_q, disc_cnt_d;
  logic                 disc_armed_q, disc_armed_d;
  logic                 disconnect_err_q, disconnect_err_d;
  logic                 rx_resetn_q, rx_resetn_d;
  logic                 enable_tx_q, enable_tx_d;
  logic                 send_null_q, send_null_d;
  logic                 send_fct_q, send_fct_d;
  logic                 send_data_q, send_data_d;
  logic [2:0]           fsm_state_q, fsm_state_d;

  logic err;
  logic timeout;
  logic got_ctrl;
  logic start_req;

`ifdef SPW_AUTOSTART_EN
  assign start_req = !bus.link_disable &&
                     (bus.link_start || (bus.auto_start && bus.rx_got_null));
`else
  logic unused_auto_start;
  assign unused_auto_start = bus.auto_start;
  assign start_req = !bus.link_disable && bus.link_start;
`endif

  assign err      = bus.rx_error || disconnect_err_q;
  assign timeout  = (timer_q == WAIT_LAST);
  assign got_ctrl = bus.rx_got_fct || bus.rx_got_nchar || bus.rx_got_time_code;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_ERROR_RESET: if (timer_q == RESET_LAST) state_d = S_ERROR_WAIT;
      S_ERROR_WAIT: begin
        if (err || got_ctrl)  state_d = S_ERROR_RESET;
        else if (timeout)     state_d = S_READY;
      end
      S_READY: begin
        if (err || got_ctrl)  state_d = S_ERROR_RESET;
        else if (start_req)   state_d = S_STARTED;
      end
      S_STARTED: begin
        if (err || got_ctrl || timeout) state_d = S_ERROR_RESET;
        else if (bus.rx_got_null)       state_d = S_CONNECTING;
      end
      S_CONNECTING: begin
        if (err || bus.rx_got_nchar || bus.rx_got_time_code || timeout)
          state_d = S_ERROR_RESET;
        else if (bus.rx_got_fct)
          state_d = S_RUN;
      end
      S_RUN: begin
        if (err || bus.credit_error || bus.link_disable) state_d = S_ERROR_RESET;
      end
      default: state_d = S_ERROR_RESET;
    endcase
  end

  // Timer restarts on every state change and sticks at all-ones.
  always_comb begin
    timer_d = timer_q;
    if (state_d != state_q)      timer_d = '0;
    else if (timer_q != COUNT_MAX) timer_d = timer_q + 1'b1;
  end

  always_comb begin
    disc_cnt_d       = disc_cnt_q;
    disc_armed_d     = disc_armed_q;
    disconnect_err_d = 1'b0;
    if (state_q == S_ERROR_RESET) begin
      disc_cnt_d   = '0;
      disc_armed_d = 1'b0;
    end else begin
      disconnect_err_d = disc_armed_q && !bus.rx_got_bit && (disc_cnt_q == DISC_LAST);
      if (bus.rx_got_bit) begin
        disc_cnt_d   = '0;
        disc_armed_d = 1'b1;
      end else if (disc_cnt_q != COUNT_MAX) begin
        disc_cnt_d = disc_cnt_q + 1'b1;
      end
    end
  end

  // Outputs are registered from the next state so they track state_q exactly.
  always_comb begin
    rx_resetn_d = (state_d != S_ERROR_RESET);
    enable_tx_d = (state_d == S_STARTED) || (state_d == S_CONNECTING) || (state_d == S_RUN);
    send_null_d = enable_tx_d;
    send_fct_d  = (state_d == S_CONNECTING) || (state_d == S_RUN);
    send_data_d = (state_d == S_RUN);
    fsm_state_d = state_d;
  end

  always_ff @(posedge pclk) begin
    if (reset) begin
      state_q          <= S_ERROR_RESET;
      timer_q          <= '0;
      disc_cnt_q       <= '0;
      disc_armed_q     <= 1'b0;
      disconnect_err_q <= 1'b0;
      rx_resetn_q      <= 1'b0;
      enable_tx_q      <= 1'b0;
      send_null_q      <= 1'b0;
      send_fct_q       <= 1'b0;
      send_data_q      <= 1'b0;
      fsm_state_q      <= 3'd0;
    end else begin
      state_q          <= state_d;
      timer_q          <= timer_d;
      disc_cnt_q       <= disc_cnt_d;
      disc_armed_q     <= disc_armed_d;
      disconnect_err_q <= disconnect_err_d;
      rx_resetn_q      <= rx_resetn_d;
      enable_tx_q      <= enable_tx_d;
      send_null_q      <= send_null_d;
      send_fct_q       <= send_fct_d;
      send_data_q      <= send_data_d;
      fsm_state_q      <= fsm_state_d;
    end
  end

  assign bus.rx_resetn      = rx_resetn_q;
  assign bus.enable_tx      = enable_tx_q;
  assign bus.send_null_tx   = send_null_q;
  assign bus.send_fct_tx    = send_fct_q;
  assign bus.send_data_tx   = send_data_q;
  assign bus.fsm_state      = fsm_state_q;
  assign bus.disconnect_err = disconnect_err_q;

endmodule

// File: tb/tb_spw_link_fsm.sv
// tb/tb_spw_link_fsm.sv - self-checking bench for spw_link_fsm against a cycle-count reference model
`timescale 1ns/1ps

module tb_spw_link_fsm;
  localparam int T6   = 640;
  localparam int T12  = 1280;
  localparam int DISC = 85;

  logic pclk = 1'b0;
  logic reset;

  spw_link_fsm_if bus();

  spw_link_fsm #(
    .T6_4US(T6), .T12_8US(T12), .DISC_CYCLES(DISC), .TIMER_W(12)
  ) dut (
    .pclk(pclk),
    .reset(reset),
    .bus(bus)
  );

  always #5 pclk = ~pclk;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: state number, cycles since entry, cycles since last bit.
  int m_state, m_time, m_since;
  bit m_armed, m_disc;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: observed 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_step();
    int  ns;
    bit  err, ctrl, new_disc;
    bit  start;
    if (reset) begin
      m_state = 0; m_time = 0; m_since = 0; m_armed = 0; m_disc = 0;
      return;
    end
    err  = bus.rx_error || m_disc;
    ctrl = bus.rx_got_fct || bus.rx_got_nchar || bus.rx_got_time_code;
    start = !bus.link_disable && bus.link_start;
`ifdef SPW_AUTOSTART_EN
    start = start || (!bus.link_disable && bus.auto_start && bus.rx_got_null);
`endif
    ns = m_state;
    case (m_state)
      0: if (m_time == T6 - 1) ns = 1;
      1: if (err || ctrl) ns = 0; else if (m_time == T12 - 1) ns = 2;
      2: if (err || ctrl) ns = 0; else if (start) ns = 3;
      3: if (err || ctrl || m_time == T12 - 1) ns = 0; else if (bus.rx_got_null) ns = 4;
      4: if (err || bus.rx_got_nchar || bus.rx_got_time_code || m_time == T12 - 1) ns = 0;
         else if (bus.rx_got_fct) ns = 5;
      5: if (err || bus.credit_error || bus.link_disable) ns = 0;
      default: ns = 0;
    endcase
    new_disc = 0;
    if (m_state == 0) begin
      m_armed = 0; m_since = 0;
    end else begin
      new_disc = m_armed && !bus.rx_got_bit && (m_since == DISC - 1);
      if (bus.rx_got_bit) begin m_since = 0; m_armed = 1; end
      else m_since++;
    end
    m_disc = new_disc;
    if (ns != m_state) m_time = 0;
    else if (m_time < 4095) m_time++;
    m_state = ns;
  endtask

  function automatic logic [8:0] dut_vec();
    return {bus.rx_resetn, bus.enable_tx, bus.send_null_tx, bus.send_fct_tx,
            bus.send_data_tx, bus.fsm_state, bus.disconnect_err};
  endfunction

  function automatic logic [8:0] exp_vec();
    return {m_state != 0, m_state >= 3, m_state >= 3, m_state >= 4,
            m_state == 5, 3'(m_state), m_disc};
  endfunction

  task automatic clear_inputs();
    bus.link_start = 0; bus.link_disable = 0; bus.auto_start = 0;
    bus.rx_got_bit = 0; bus.rx_got_null = 0; bus.rx_got_fct = 0;
    bus.rx_got_nchar = 0; bus.rx_got_time_code = 0;
    bus.rx_error = 0; bus.credit_error = 0;
  endtask

  task automatic cycle();
    @(posedge pclk);
    model_step();
    #1;
    check("outputs", 32'(dut_vec()), 32'(exp_vec()));
    // The receiver's sticky flags only clear while it is held in reset.
    if (m_state == 0) begin
      bus.rx_got_null = 0; bus.rx_got_fct = 0;
      bus.rx_got_nchar = 0; bus.rx_got_time_code = 0;
    end
  endtask

  task automatic do_reset();
    clear_inputs();
    reset = 1;
    cycle();
    cycle();
    reset = 0;
  endtask

  task automatic wait_state(input int s, input int bound);
    int n = 0;
    while (bus.fsm_state != 3'(s) && n < bound) begin
      cycle();
      n++;
    end
    check("reach_state", 32'(bus.fsm_state), 32'(s));
  endtask

  task automatic dwell(input int s, output int n);
    n = 0;
    while (bus.fsm_state == 3'(s) && n < 5000) begin
      cycle();
      n++;
    end
  endtask

  task automatic to_connecting();
    do_reset();
    wait_state(2, 2500);
    bus.link_start = 1;
    cycle();
    bus.link_start = 0;
    bus.rx_got_null = 1;
    cycle();
    check("connecting_state", 32'(bus.fsm_state), 32'd4);
  endtask

  task automatic to_run();
    to_connecting();
    bus.rx_got_fct = 1;
    cycle();
    check("run_state", 32'(bus.fsm_state), 32'd5);
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int n;
    int k;
    bit active;
    clear_inputs();
    reset = 1;
    cycle();
    check("reset_rx_resetn", 32'(bus.rx_resetn), 0);
    check("reset_enable_tx", 32'(bus.enable_tx), 0);
    check("reset_state", 32'(bus.fsm_state), 0);
    check("reset_disc", 32'(bus.disconnect_err), 0);

    // Idle power-up sequence and dwell times.
    do_reset();
    dwell(0, n);
    check("error_reset_cycles", 32'(n), 32'(T6));
    check("rx_resetn_at_wait", 32'(bus.rx_resetn), 1);
    dwell(1, n);
    check("error_wait_cycles", 32'(n), 32'(T12));
    repeat (50) cycle();
    check("ready_holds", 32'(bus.fsm_state), 2);

    // Normal start: Started -> Connecting -> Run, then host disable.
    bus.link_start = 1;
    cycle();
    check("started", 32'(bus.fsm_state), 3);
    bus.link_start = 0;
    repeat (99) cycle();
    bus.rx_got_null = 1;
    cycle();
    check("connecting", 32'(bus.fsm_state), 4);
    repeat (199) cycle();
    bus.rx_got_fct = 1;
    cycle();
    check("run", 32'(bus.fsm_state), 5);
    check("run_tx_enables",
          32'({bus.enable_tx, bus.send_null_tx, bus.send_fct_tx, bus.send_data_tx}), 32'hF);
    bus.link_disable = 1;
    cycle();
    check("run_link_disable", 32'(bus.fsm_state), 0);
    bus.link_disable = 0;

    // Started timeout.
    do_reset();
    wait_state(2, 2500);
    bus.link_start = 1;
    cycle();
    bus.link_start = 0;
    dwell(3, n);
    check("started_timeout_cycles", 32'(n), 32'(T12));
    check("started_timeout_state", 32'(bus.fsm_state), 0);
    check("started_timeout_rx_resetn", 32'(bus.rx_resetn), 0);

    // Connecting timeout.
    to_connecting();
    dwell(4, n);
    check("connecting_timeout_cycles", 32'(n), 32'(T12));
    check("connecting_timeout_state", 32'(bus.fsm_state), 0);

    // Disconnect detection in Run.
    to_run();
    for (int i = 0; i < 10; i++) begin
      repeat (9) cycle();
      bus.rx_got_bit = 1;
      cycle();
      bus.rx_got_bit = 0;
    end
    check("run_with_bits", 32'(bus.fsm_state), 5);
    k = 0;
    do begin
      cycle();
      k++;
    end while (!bus.disconnect_err && k < 200);
    check("disconnect_delay", 32'(k), 32'(DISC));
    cycle();
    check("disconnect_pulse_width", 32'(bus.disconnect_err), 0);
    check("disconnect_state", 32'(bus.fsm_state), 0);

    // fct and rx_error together in Connecting.
    to_connecting();
    bus.rx_got_fct = 1;
    bus.rx_error = 1;
    cycle();
    check("fct_with_error", 32'(bus.fsm_state), 0);
    bus.rx_error = 0;

    // Credit error in Run.
    to_run();
    bus.credit_error = 1;
    cycle();
    check("credit_error", 32'(bus.fsm_state), 0);
    bus.credit_error = 0;

    // Auto-start request in Ready.
    do_reset();
    wait_state(2, 2500);
    bus.auto_start = 1;
    bus.rx_got_null = 1;
    cycle();
`ifdef SPW_AUTOSTART_EN
    check("auto_start", 32'(bus.fsm_state), 3);
`else
    check("auto_start_ignored", 32'(bus.fsm_state), 2);
`endif

    // Reset asserted mid-Run.
    to_run();
    reset = 1;
    cycle();
    check("midrun_rx_resetn", 32'(bus.rx_resetn), 0);
    check("midrun_tx", 32'({bus.enable_tx, bus.send_null_tx, bus.send_fct_tx, bus.send_data_tx}), 0);
    check("midrun_state", 32'(bus.fsm_state), 0);
    check("midrun_disc", 32'(bus.disconnect_err), 0);
    reset = 0;

    // Randomized traffic against the model.
    do_reset();
    active = 1;
    for (int c = 0; c < 30000; c++) begin
      if (c % 256 == 0) active = ($urandom_range(0, 2) != 0);
      bus.rx_got_bit   = active && ($urandom_range(0, 3) == 0);
      bus.link_start   = ($urandom_range(0, 15) == 0);
      bus.link_disable = ($urandom_range(0, 199) == 0);
      bus.auto_start   = $urandom_range(0, 1) != 0;
      bus.rx_error     = ($urandom_range(0, 2999) == 0);
      bus.credit_error = ($urandom_range(0, 2999) == 0);
      if ($urandom_range(0, (m_state >= 2) ? 59 : 3999) == 0) bus.rx_got_null = 1;
      if ($urandom_range(0, (m_state >= 3) ? 149 : 3999) == 0) bus.rx_got_fct = 1;
      if ($urandom_range(0, 999) == 0) bus.rx_got_nchar = 1;
      if ($urandom_range(0, 1999) == 0) bus.rx_got_time_code = 1;
      cycle();
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/spw_link_fsm.md
Name: spw_link_fsm

Overview:
- Link-interface controller for the SpaceWire receiver/transmitter pair, per the ECSS-E-ST-50-12C exchange-level state machine.
- Sequences the six link states: ErrorReset, ErrorWait, Ready, Started, Connecting, Run.
- Drives the receiver's active-low reset and the transmitter's NULL/FCT/data enables.
- Monitors receiver status flags and performs disconnect detection.

Parameters:
- T6_4US, 640: pclk cycles spent in ErrorReset (6.4 us at 100 MHz).
- T12_8US, 1280: pclk cycles for the ErrorWait dwell and for the Started/Connecting timeouts.
- DISC_CYCLES, 85: pclk cycles without rx_got_bit that constitute a disconnect (850 ns).
- TIMER_W, 12: width of the shared timer. Must hold max(T12_8US, DISC_CYCLES).

Ports:
- pclk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- link_start  in  1  host request to start the link.
- link_disable  in  1  host forces the link down.
- auto_start  in  1  start when a NULL is received (see Optional Feature).
- rx_got_bit  in  1  receiver bit-activity pulse.
- rx_got_null  in  1  sticky flag: NULL received since rx reset.
- rx_got_fct  in  1  sticky flag: FCT received.
- rx_got_nchar  in  1  sticky flag: N-char received.
- rx_got_time_code  in  1  sticky flag: time-code received.
- rx_error  in  1  receiver parity/escape error.
- credit_error  in  1  credit overflow reported by the flow-control logic.
- rx_resetn  out  1  active-low reset for the receiver.
- enable_tx  out  1  transmitter enabled.
- send_null_tx  out  1  transmitter sends NULLs.
- send_fct_tx  out  1  transmitter may send FCTs.
- send_data_tx  out  1  transmitter may send N-chars and time-codes.
- fsm_state  out  3  current state encoding: 0 ErrorReset, 1 ErrorWait, 2 Ready, 3 Started, 4 Connecting, 5 Run.
- disconnect_err  out  1  one-cycle pulse when a disconnect is detected.

Behaviour:
- All inputs are synchronous to pclk; synchronization happens upstream.
- All outputs are registered and reflect the current state. The first output change occurs one cycle after the transition condition is sampled.
- Reset (at any time, including mid-Run): next edge enters ErrorReset; timer=0; disc_armed=0. Outputs: rx_resetn=0, enable_tx=0, send_null_tx=0, send_fct_tx=0, send_data_tx=0, fsm_state=0, disconnect_err=0.
- Timer: cleared on every state entry, then increments once per cycle. It saturates at all-ones and does not wrap.
- Output decode by state:
  - rx_resetn = 0 only in ErrorReset.
  - enable_tx and send_null_tx = 1 in Started, Connecting, Run.
  - send_fct_tx = 1 in Connecting and Run.
  - send_data_tx = 1 only in Run.
- Disconnect detector:
  - disc_cnt clears on every rx_got_bit. The first rx_got_bit after leaving ErrorReset sets disc_armed.
  - When armed and disc_cnt == DISC_CYCLES-1 without rx_got_bit, disconnect_err pulses for 1 cycle.
  - disc_armed and disc_cnt clear whenever in ErrorReset.
- err = rx_error | disconnect_err. err takes priority over every forward transition.
- ErrorReset: when timer == T6_4US-1, go to ErrorWait.
- ErrorWait:
  - err, rx_got_fct, rx_got_nchar or rx_got_time_code: go to ErrorReset.
  - Otherwise, when timer == T12_8US-1, go to Ready.
- Ready:
  - err or any of fct/nchar/time_code: go to ErrorReset.
  - Otherwise, if link_disable=0 and link_start=1 (or the auto-start condition holds), go to Started.
- Started:
  - err, fct, nchar, time_code, or timer == T12_8US-1: go to ErrorReset.
  - Otherwise, rx_got_null: go to Connecting.
- Connecting:
  - err, nchar, time_code, or timer == T12_8US-1: go to ErrorReset.
  - Otherwise, rx_got_fct: go to Run.
- Run: err, credit_error or link_disable: go to ErrorReset. Otherwise stay.
- Simultaneous events:
  - rx_got_fct and rx_error in the same cycle in Connecting: go to ErrorReset.
  - Timeout and rx_got_null in the same cycle in Started: go to ErrorReset.
- Sticky rx flags are cleared only by the receiver's own reset. ErrorReset drives rx_resetn low for T6_4US cycles, which guarantees they are clear on entry to ErrorWait.
- Illegal fsm_state encodings (6, 7) go to ErrorReset on the next edge.

Optional Feature:
- Macro: SPW_AUTOSTART_EN.
- Defined: in Ready, auto_start=1 && rx_got_null=1 && link_disable=0 also transitions to Started.
- Undefined: the auto_start port exists but is ignored; only link_start starts the link.

Test Plan:
- Reset then idle inputs: fsm_state 0 for 640 cycles, 1 for 1280 cycles, then 2 and holds. rx_resetn rises exactly at the 0->1 transition.
- Ready; link_start=1; rx_got_null at 100 cycles later; rx_got_fct at 200 cycles later: states 3 -> 4 -> 5. In Run, enable_tx, send_null_tx, send_fct_tx and send_data_tx are all 1.
- Started with no rx_got_null: on cycle 1280 the state returns to 0 and rx_resetn=0. Repeat in Connecting without fct: same result.
- Run; pulse rx_got_bit every 10 cycles, then stop: disconnect_err pulses 85 cycles after the last bit, and the next state is 0.
- Connecting; rx_got_fct=1 and rx_error=1 in the same cycle: next state is 0, not 5. In Run, link_disable=1 or credit_error=1 gives state 0 next cycle.
- SPW_AUTOSTART_EN defined: Ready, link_start=0, auto_start=1, rx_got_null=1 gives state 3. Macro undefined: the same stimulus holds state 2. Assert reset mid-Run: all outputs reach reset values on the next edge.
